// File: rtl/alu_operand_stage_if.sv
// Operand-stage bus: decode-side request, forwarding taps and ALU-side result.
// The slave modport is the stage itself; master is the surrounding pipeline.
interface alu_operand_stage_if #(
    parameter int W  = 32,
    parameter int RA = 5
);
    // decode side
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_rdata1;
    logic [W-1:0]  in_rdata2;
    logic [RA-1:0] in_rs;
    logic [RA-1:0] in_rt;
    logic [15:0]   in_imm;
    logic          in_imm_sext;
    logic          in_alusrc;
    logic [3:0]    in_ctrl;
    logic [RA-1:0] in_wreg;

    // forwarding taps from EX/MEM and MEM/WB
    logic          ex_we;
    logic [RA-1:0] ex_wreg;
    logic [W-1:0]  ex_wdata;
    logic          wb_we;
    logic [RA-1:0] wb_wreg;
    logic [W-1:0]  wb_wdata;

    // ALU side
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_a;
    logic [W-1:0]  out_b;
    logic [3:0]    out_ctrl;
    logic [W-1:0]  out_sdata;
    logic [RA-1:0] out_wreg;

    modport master (
        output in_valid, in_rdata1, in_rdata2, in_rs, in_rt, in_imm,
               in_imm_sext, in_alusrc, in_ctrl, in_wreg,
        output ex_we, ex_wreg, ex_wdata, wb_we, wb_wreg, wb_wdata,
        output out_ready,
        input  in_ready,
        input  out_valid, out_a, out_b, out_ctrl, out_sdata, out_wreg
    );

    modport slave (
        input  in_valid, in_rdata1, in_rdata2, in_rs, in_rt, in_imm,
               in_imm_sext, in_alusrc, in_ctrl, in_wreg,
        input  ex_we, ex_wreg, ex_wdata, wb_we, wb_wreg, wb_wdata,
        input  out_ready,
        output in_ready,
        output out_valid, out_a, out_b, out_ctrl, out_sdata, out_wreg
    );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: forwarding, ALUSrc immediate mux and a two-entry skid buffer.
// Forwarding from EX/MEM and MEM/WB is built only when ALU_OPERAND_FWD_EN is defined.
module alu_operand_stage #(
    parameter int W  = 32,
    parameter int RA = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    alu_operand_stage_if.slave bus
);

    typedef struct packed {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [W-1:0]  sdata;
        logic [3:0]    ctrl;
        logic [RA-1:0] wreg;
    } entry_t;

    logic [W-1:0] w_fa;
    logic [W-1:0] w_fb;
    logic [W-1:0] w_imm32;
    entry_t       w_entry;
    logic         w_in_fire;
    logic         w_main_load;
    logic         w_skid_load;

    entry_t       r_main;
    entry_t       r_skid;
    logic         r_out_valid;
    logic         r_skid_valid;

`ifdef ALU_OPERAND_FWD_EN
    // EX/MEM is the younger producer, so it wins over MEM/WB; r0 never forwards.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_fa = bus.in_rdata1;
        if (bus.in_rs != '0 && bus.ex_we && bus.ex_wreg == bus.in_rs)
            w_fa = bus.ex_wdata;
        else if (bus.in_rs != '0 && bus.wb_we && bus.wb_wreg == bus.in_rs)
            w_fa = bus.wb_wdata;

        w_fb = bus.in_rdata2;
        if (bus.in_rt != '0 && bus.ex_we && bus.ex_wreg == bus.in_rt)
            w_fb = bus.ex_wdata;
        else if (bus.in_rt != '0 && bus.wb_we && bus.wb_wreg == bus.in_rt)
            w_fb = bus.wb_wdata;
    end
`else
    logic w_unused_fwd;

    assign w_fa = bus.in_rdata1;
    assign w_fb = bus.in_rdata2;
    assign w_unused_fwd = ^{bus.ex_we, bus.ex_wreg, bus.ex_wdata,
                            bus.wb_we, bus.wb_wreg, bus.wb_wdata};
`endif

    assign w_imm32 = bus.in_imm_sext ? {{16{bus.in_imm[15]}}, bus.in_imm}
                                     : {16'b0, bus.in_imm};

    assign w_entry.a     = w_fa;
    assign w_entry.b     = bus.in_alusrc ? w_imm32 : w_fb;
    assign w_entry.sdata = w_fb;
    assign w_entry.ctrl  = bus.in_ctrl;
    assign w_entry.wreg  = bus.in_wreg;

    // in_ready is purely registered, which keeps out_ready off the decode path.
    assign w_in_fire   = bus.in_valid & ~r_skid_valid;
    assign w_main_load = ~r_out_valid | bus.out_ready;
    assign w_skid_load = w_in_fire & ~w_main_load;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            if (w_main_load) begin
                r_out_valid  <= r_skid_valid | w_in_fire;
                r_skid_valid <= 1'b0;
            end else if (w_skid_load) begin
                r_skid_valid <= 1'b1;
            end
        end
    end

    // Skid entry always drains ahead of new input to preserve order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main <= '0;
        end else if (!flush && w_main_load) begin
            if (r_skid_valid)
                r_main <= r_skid;
            else if (w_in_fire)
                r_main <= w_entry;
        end
    end

    // NOTE: skid payload has no reset; it is never observed while r_skid_valid is low.
    always_ff @(posedge clk) begin
        if (w_skid_load)
            r_skid <= w_entry;
    end

    assign bus.in_ready  = ~r_skid_valid;
    assign bus.out_valid = r_out_valid;
    assign bus.out_a     = r_main.a;
    assign bus.out_b     = r_main.b;
    assign bus.out_sdata = r_main.sdata;
    assign bus.out_ctrl  = r_main.ctrl;
    assign bus.out_wreg  = r_main.wreg;

endmodule
